// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - memory-side responder for the core RAM request interface
//
// Serves level-sensitive read/write requests from an internal word-addressed
// array of 2^ADDR_WIDTH 32-bit words, completing each access WAIT_STATES edges
// after it is sampled (WAIT_STATES=0 completes on the sampling edge itself).
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   ramAddress   word address from the core
//   ramOut       write data from the core
//   readReq      read request (level, may be held)
//   writeReq     write request (level)
//   ramIn        registered read data; holds between reads
//   dataValid    one-cycle pulse: read completed, ramIn updated
//   writeAck     one-cycle pulse: write completed or dropped
//   busy         high while an access is waiting out its wait states
//   outOfRange   sticky: some access used an address >= 2^ADDR_WIDTH
//   accessCount  completed accesses, wrapping
module ram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ramAddress,
  input  logic [31:0] ramOut,
  input  logic        readReq,
  input  logic        writeReq,
  output logic [31:0] ramIn,
  output logic        dataValid,
  output logic        writeAck,
  output logic        busy,
  output logic        outOfRange,
  output logic [31:0] accessCount
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  logic [31:0] mem [2**ADDR_WIDTH];

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] ram_in_q, ram_in_d;
  logic        data_valid_q, data_valid_d;
  logic        write_ack_q, write_ack_d;
  logic        busy_q, busy_d;
  logic        oor_q, oor_d;
  logic [31:0] count_q, count_d;

  // Access actually being completed this edge: either straight from the
  // inputs (zero wait states) or from the latched request.
  logic                  do_access;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_data;
  logic                  acc_rd;
  logic                  acc_wr;
  logic                  acc_in_range;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic                  mem_we;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    ram_in_d     = ram_in_q;
    data_valid_d = 1'b0;
    write_ack_d  = 1'b0;
    oor_d        = oor_q;
    count_d      = count_q;
    do_access    = 1'b0;
    acc_addr     = addr_q;
    acc_data     = wdata_q;
    acc_rd       = rd_q;
    acc_wr       = wr_q;

    case (state_q)
      ST_IDLE: begin
        if (readReq || writeReq) begin
          addr_d  = ramAddress;
          wdata_d = ramOut;
          rd_d    = readReq;
          wr_d    = writeReq;
          if (WAIT_STATES == 0) begin
            do_access = 1'b1;
            acc_addr  = ramAddress;
            acc_data  = ramOut;
            acc_rd    = readReq;
            acc_wr    = writeReq;
          end else begin
            cnt_d   = 8'(WAIT_STATES);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          do_access = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    acc_in_range = (acc_addr[31:ADDR_WIDTH] == '0);
    acc_idx      = acc_addr[ADDR_WIDTH-1:0];
    mem_we       = do_access && acc_wr && acc_in_range;

    if (do_access) begin
      count_d = count_q + 32'd1;
      if (!acc_in_range) oor_d = 1'b1;
      if (acc_wr) write_ack_d = 1'b1;
      if (acc_rd) begin
        data_valid_d = 1'b1;
        // Write-first: a combined access returns the data just written.
        if (!acc_in_range)  ram_in_d = 32'h0;
        else if (acc_wr)    ram_in_d = acc_data;
        else                ram_in_d = mem[acc_idx];
      end
    end

    busy_d = (state_d == ST_WAIT);
  end

  // Array is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[acc_idx] <= acc_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      ram_in_q     <= 32'h0;
      data_valid_q <= 1'b0;
      write_ack_q  <= 1'b0;
      busy_q       <= 1'b0;
      oor_q        <= 1'b0;
      count_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      ram_in_q     <= ram_in_d;
      data_valid_q <= data_valid_d;
      write_ack_q  <= write_ack_d;
      busy_q       <= busy_d;
      oor_q        <= oor_d;
      count_q      <= count_d;
    end
  end

  assign ramIn       = ram_in_q;
  assign dataValid   = data_valid_q;
  assign writeAck    = write_ack_q;
  assign busy        = busy_q;
  assign outOfRange  = oor_q;
  assign accessCount = count_q;

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - self-checking bench for ram_responder (0 and 3 wait states)
module tb_ram_responder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance 0: WAIT_STATES=0, instance 1: WAIT_STATES=3
  logic [31:0] addr_i [2];
  logic [31:0] wd_i   [2];
  logic        rd_i   [2];
  logic        wr_i   [2];
  logic [31:0] ram_o  [2];
  logic        dv_o   [2];
  logic        wa_o   [2];
  logic        busy_o [2];
  logic        oor_o  [2];
  logic [31:0] cnt_o  [2];

  ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut_a (
    .clk(clk), .reset(rst_n), .ramAddress(addr_i[0]), .ramOut(wd_i[0]),
    .readReq(rd_i[0]), .writeReq(wr_i[0]), .ramIn(ram_o[0]), .dataValid(dv_o[0]),
    .writeAck(wa_o[0]), .busy(busy_o[0]), .outOfRange(oor_o[0]), .accessCount(cnt_o[0])
  );

  ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut_b (
    .clk(clk), .reset(rst_n), .ramAddress(addr_i[1]), .ramOut(wd_i[1]),
    .readReq(rd_i[1]), .writeReq(wr_i[1]), .ramIn(ram_o[1]), .dataValid(dv_o[1]),
    .writeAck(wa_o[1]), .busy(busy_o[1]), .outOfRange(oor_o[1]), .accessCount(cnt_o[1])
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passes++;
  endtask

  // ---------------- transaction-level model ----------------
  int          ws [2] = '{0, 3};
  logic [31:0] m_mem [2][1024];
  int          edge_no [2];
  int          done_at [2];
  logic        pend [2];
  logic [31:0] l_addr [2], l_data [2];
  logic        l_rd [2], l_wr [2];
  logic [31:0] exp_ram [2], exp_cnt [2];
  logic        exp_dv [2], exp_wa [2], exp_busy [2], exp_oor [2];

  task automatic complete(input int i);
    logic inr;
    inr = (l_addr[i] >> 10) == 0;
    if (l_wr[i] && inr) m_mem[i][l_addr[i][9:0]] = l_data[i];
    if (l_rd[i]) begin
      exp_ram[i] = inr ? m_mem[i][l_addr[i][9:0]] : 32'h0;
      exp_dv[i]  = 1'b1;
    end
    if (l_wr[i]) exp_wa[i] = 1'b1;
    if (!inr) exp_oor[i] = 1'b1;
    exp_cnt[i] = exp_cnt[i] + 1;
  endtask

  task automatic model_edge(input int i);
    exp_dv[i] = 1'b0;
    exp_wa[i] = 1'b0;
    edge_no[i]++;
    if (pend[i]) begin
      if (edge_no[i] == done_at[i]) begin
        pend[i] = 1'b0;
        complete(i);
      end
    end else if (rd_i[i] || wr_i[i]) begin
      l_addr[i] = addr_i[i];
      l_data[i] = wd_i[i];
      l_rd[i]   = rd_i[i];
      l_wr[i]   = wr_i[i];
      if (ws[i] == 0) complete(i);
      else begin
        pend[i]    = 1'b1;
        done_at[i] = edge_no[i] + ws[i];
      end
    end
    exp_busy[i] = pend[i];
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        edge_no[i] = 0; done_at[i] = 0; pend[i] = 1'b0;
        exp_ram[i] = 32'h0; exp_cnt[i] = 32'h0;
        exp_dv[i] = 1'b0; exp_wa[i] = 1'b0; exp_busy[i] = 1'b0; exp_oor[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_edge(i);
    end
  end

  logic cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model_ramIn[%0d]", i), ram_o[i], exp_ram[i]);
        chk($sformatf("model_dataValid[%0d]", i), 32'(dv_o[i]), 32'(exp_dv[i]));
        chk($sformatf("model_writeAck[%0d]", i), 32'(wa_o[i]), 32'(exp_wa[i]));
        chk($sformatf("model_busy[%0d]", i), 32'(busy_o[i]), 32'(exp_busy[i]));
        chk($sformatf("model_outOfRange[%0d]", i), 32'(oor_o[i]), 32'(exp_oor[i]));
        chk($sformatf("model_accessCount[%0d]", i), cnt_o[i], exp_cnt[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int i, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    rd_i[i] = rd; wr_i[i] = wr; addr_i[i] = a; wd_i[i] = d;
  endtask

  task automatic idle(input int i);
    drive(i, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // One access on the 3-wait-state instance; returns after the completion edge.
  task automatic acc_b(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    drive(1, rd, wr, a, d);
    @(negedge clk);
    idle(1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle(0); idle(1);
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_ramIn", ram_o[0], 32'h0);
    chk("reset_count", cnt_o[0], 32'h0);

    // Zero wait states: write then read back
    drive(0, 1'b0, 1'b1, 32'd5, 32'hCAFEF00D);
    @(negedge clk);
    chk("ws0_write_ack", 32'(wa_o[0]), 32'd1);
    chk("ws0_write_count", cnt_o[0], 32'd1);
    drive(0, 1'b1, 1'b0, 32'd5, 32'h0);
    @(negedge clk);
    chk("ws0_read_data", ram_o[0], 32'hCAFEF00D);
    chk("ws0_read_dv", 32'(dv_o[0]), 32'd1);
    chk("ws0_read_count", cnt_o[0], 32'd2);
    idle(0);
    @(negedge clk);
    chk("ws0_ramIn_holds", ram_o[0], 32'hCAFEF00D);

    // Preload 0..2 with writeReq held, then stream reads with readReq held
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b0, 1'b1, 32'(k), 32'h11 * (k + 1));
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 1'b1, 1'b0, 32'(k), 32'h0);
      @(negedge clk);
      chk($sformatf("stream_data%0d", k), ram_o[0], 32'h11 * (k + 1));
      chk($sformatf("stream_dv%0d", k), 32'(dv_o[0]), 32'd1);
    end

    // Combined read+write: write-first, single count
    drive(0, 1'b1, 1'b1, 32'd7, 32'h12345678);
    @(negedge clk);
    chk("rw_ack", 32'(wa_o[0]), 32'd1);
    chk("rw_dv", 32'(dv_o[0]), 32'd1);
    chk("rw_data", ram_o[0], 32'h12345678);
    chk("rw_count", cnt_o[0], 32'd9);

    // Out-of-range write/read, no aliasing onto word 0
    drive(0, 1'b0, 1'b1, 32'h400, 32'hBADBAD00);
    @(negedge clk);
    chk("oor_write_ack", 32'(wa_o[0]), 32'd1);
    chk("oor_set", 32'(oor_o[0]), 32'd1);
    drive(0, 1'b1, 1'b0, 32'h400, 32'h0);
    @(negedge clk);
    chk("oor_read_zero", ram_o[0], 32'h0);
    drive(0, 1'b1, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("oor_no_alias", ram_o[0], 32'h11);
    chk("oor_sticky", 32'(oor_o[0]), 32'd1);
    chk("oor_count", cnt_o[0], 32'd12);
    idle(0);

    // Three wait states: preload, then read 5 with address changed after sampling
    acc_b(1'b0, 1'b1, 32'd5, 32'h55AA55AA);
    acc_b(1'b0, 1'b1, 32'd9, 32'h00000099);
    acc_b(1'b0, 1'b1, 32'd3, 32'h33333333);
    drive(1, 1'b1, 1'b0, 32'd5, 32'h0);
    @(negedge clk);
    chk("ws3_busy1", 32'(busy_o[1]), 32'd1);
    drive(1, 1'b0, 1'b0, 32'd9, 32'h0);
    @(negedge clk);
    chk("ws3_busy2", 32'(busy_o[1]), 32'd1);
    @(negedge clk);
    chk("ws3_busy3", 32'(busy_o[1]), 32'd1);
    chk("ws3_no_dv_early", 32'(dv_o[1]), 32'd0);
    @(negedge clk);
    chk("ws3_dv", 32'(dv_o[1]), 32'd1);
    chk("ws3_data", ram_o[1], 32'h55AA55AA);
    chk("ws3_busy_clear", 32'(busy_o[1]), 32'd0);
    chk("ws3_count", cnt_o[1], 32'd4);

    // Reset asserted while a write to 3 is pending
    drive(1, 1'b0, 1'b1, 32'd3, 32'hDEADBEEF);
    @(negedge clk);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ramIn", ram_o[1], 32'h0);
    chk("async_count", cnt_o[1], 32'h0);
    chk("async_busy", 32'(busy_o[1]), 32'd0);
    chk("async_oor_a", 32'(oor_o[0]), 32'd0);
    chk("async_ramIn_a", ram_o[0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_ack", 32'(wa_o[1]), 32'd0);
    chk("post_reset_count", cnt_o[1], 32'd0);
    acc_b(1'b1, 1'b0, 32'd3, 32'h0);
    chk("abandoned_write", ram_o[1], 32'h33333333);
    chk("abandoned_count", cnt_o[1], 32'd1);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder for the core's RAM request interface.
- Accepts the core's ramAddress, ramOut, readReq and writeReq, and serves them from an internal word-addressed memory array.
- Returns read data on ramIn with fixed, parameterised latency. Zero wait states meets the core's two-edge instruction-fetch timing.
- Adds completion strobes, a busy flag, a sticky range error and an access counter for future cores and debug.

Parameters:
- ADDR_WIDTH, 10, word-address bits; array depth 2^ADDR_WIDTH 32-bit words.
- WAIT_STATES, 0, extra edges between request sampling and access completion (0..255).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset.
- ramAddress  input  32  word address from the core.
- ramOut  input  32  write data from the core.
- readReq  input  1  read request, level-sensitive, may be held high indefinitely.
- writeReq  input  1  write request, level-sensitive.
- ramIn  output  32  read data to the core, registered.
- dataValid  output  1  one-cycle pulse: read completed, ramIn updated.
- writeAck  output  1  one-cycle pulse: write completed or rejected.
- busy  output  1  high while in WAIT.
- outOfRange  output  1  sticky: an access used an address >= 2^ADDR_WIDTH.
- accessCount  output  32  completed accesses; wraps 0xFFFFFFFF -> 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE.
  - ramIn, dataValid, writeAck, busy, outOfRange, accessCount all 0.
  - Latched request registers cleared.
  - Memory array contents not cleared.
- States are IDLE and WAIT. dataValid and writeAck default to 0 on every edge unless set below.
- IDLE, sampling edge S with readReq or writeReq = 1:
  - Latch address, write data, rd and wr flags.
  - If WAIT_STATES=0, complete the access at S and stay IDLE.
  - Otherwise load cnt=WAIT_STATES and go WAIT.
- WAIT:
  - Each edge decrements cnt.
  - At the edge where cnt==1, complete the access and go IDLE.
  - Access completes at edge S+WAIT_STATES.
  - Inputs are ignored while in WAIT; the latched values are used.
- Completion:
  - Write: if the latched address is in range, store the data; else drop the write. writeAck=1 in both cases.
  - Read: ramIn = mem[addr] if in range, else 0x00000000. dataValid=1.
  - Read and write together: write-first. The write is performed, ramIn returns the new data, and both strobes pulse.
  - accessCount +1 per completion; a combined read+write counts as 1.
  - An out-of-range access sets outOfRange=1. It stays set until reset.
- Throughput: one access per WAIT_STATES+1 edges. A held readReq re-samples on the first IDLE edge after each completion.
- With WAIT_STATES=0 and readReq held, ramIn tracks mem[ramAddress] one edge behind. This supports the core flow: request visible after E0, sampled at E1, core captures ramIn at E2.
- ramIn holds its value between reads; writes alone do not change it.
- Addressing:
  - Range check: in range iff ramAddress[31:ADDR_WIDTH]==0.
  - Index = ramAddress[ADDR_WIDTH-1:0].
  - No aliasing: an out-of-range address never touches the array.
- Reset during WAIT: the pending access is abandoned (write not performed, no strobe) and accessCount is not incremented.
- A request present when reset deasserts is sampled on the first edge after release.

Test Plan:
- Assert reset=0 mid-run -> all outputs 0 immediately (asynchronous), state IDLE; release, no requests -> outputs remain 0.
- WAIT_STATES=0: writeReq one cycle, addr 5, data 0xCAFEF00D -> writeAck pulse, accessCount=1. Then readReq, addr 5 -> one edge later ramIn=0xCAFEF00D, dataValid=1, accessCount=2.
- WAIT_STATES=0, preload mem[0..2]=0x11,0x22,0x33, readReq held high, address 0,1,2 on successive cycles -> ramIn=0x11,0x22,0x33 one edge behind, dataValid high each cycle.
- readReq and writeReq together, addr 7, data 0x12345678 -> same edge: writeAck=1, dataValid=1, ramIn=0x12345678, accessCount +1 only.
- WAIT_STATES=3: read addr 5, changing ramAddress to 9 after sampling -> busy=1 for 3 cycles, dataValid at edge S+3, ramIn=mem[5].
- ADDR_WIDTH=10, write 0xBADBAD00 to 0x400 then read 0x400 and 0x000 -> first read returns 0, outOfRange=1 sticky, mem[0] unchanged.
- Optional: WAIT_STATES=3, write addr 3, reset pulsed in WAIT -> no writeAck, mem[3] unchanged, accessCount=0.
